mips_pipe_param: RTL and testbench

Parametrised single-clock 5-stage (IF/ID/EX/MEM/WB) integer core implementing the team's MIPS-style 32-bit instruction encoding over a DW-bit datapath. It replaces the two-phase-clock core and adds hardware hazard handling:

- full forwarding
- a load-use interlock
- branch flush

Programs therefore run without inserted dummy instructions. It sits under the processor test benches, with program load and data-memory readback ports for the bench.

---
 rtl/mips_pipe_param_if.sv | 26 ++
 rtl/mips_pipe_param.sv | 208 ++++++++++++++++++++
 tb/tb_mips_pipe_param.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_param_if.sv
// Bench-facing bundle for mips_pipe_param: run control, program load,
// data-memory readback and retirement status.
interface mips_pipe_param_if #(
  parameter int DW         = 64,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
);
  logic                          run;
  logic                          prog_we;
  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr;
  logic [31:0]                   prog_data;
  logic [$clog2(DMEM_DEPTH)-1:0] dbg_addr;
  logic [DW-1:0]                 dbg_data;
  logic                          halted;
  logic [31:0]                   retired;

  modport master (
    output run, prog_we, prog_addr, prog_data, dbg_addr,
    input  dbg_data, halted, retired
  );

  modport slave (
    input  run, prog_we, prog_addr, prog_data, dbg_addr,
    output dbg_data, halted, retired
  );
endinterface

// File: rtl/mips_pipe_param.sv
// Single-clock 5-stage MIPS-style integer core (IF/ID/EX/MEM/WB) with full
// forwarding, load-use interlock and EX-resolved branches with IF/ID flush.
module mips_pipe_param #(
  parameter int DW         = 64,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input logic              clk,
  input logic              rst_n,
  mips_pipe_param_if.slave bus
);
  localparam int PW = $clog2(IMEM_DEPTH);
  localparam int AW = $clog2(DMEM_DEPTH);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG6 = 6'(NREG);

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010,
    OP_OR    = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101,
    OP_LW    = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010,
    OP_SUBI  = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110, OP_HLT  = 6'b111111
  } op_e;

  logic [31:0]   imem [IMEM_DEPTH];
  logic [DW-1:0] dmem [DMEM_DEPTH];
  logic [DW-1:0] rf   [NREG];

  logic [PW-1:0] pc;
  logic          hlt_pend, halted_q;
  logic [31:0]   retired_q;

  // IF/ID
  logic          id_valid;
  logic [31:0]   id_instr;
  logic [PW-1:0] id_pc;
  // ID/EX
  logic          ex_valid, ex_wr;
  logic [5:0]    ex_op;
  logic [PW-1:0] ex_pc;
  logic [DW-1:0] ex_a, ex_b, ex_imm;
  logic [4:0]    ex_rs, ex_rt, ex_dst;
  // EX/MEM
  logic          mem_valid, mem_wr;
  logic [5:0]    mem_op;
  logic [DW-1:0] mem_res, mem_sd;
  logic [4:0]    mem_dst;
  // MEM/WB
  logic          wb_valid, wb_wr;
  logic [5:0]    wb_op;
  logic [DW-1:0] wb_val;
  logic [4:0]    wb_dst;

  logic [5:0]    id_op;
  logic [4:0]    id_rs, id_rt, id_dst;
  logic [DW-1:0] id_a, id_b, id_imm;
  logic          id_rr, id_ri, id_wr, id_use_rs, id_use_rt, id_hlt;
  logic [DW-1:0] fa, fb, ex_res;
  logic          br_taken, ld_use, fetch_en;
  logic [PW-1:0] br_target;
  logic [AW-1:0] mem_addr;

  // Register read with write-through from the WB stage; out-of-range and R0 read 0.
  function automatic logic [DW-1:0] rf_rd(input logic [4:0] idx);
    if (idx == 5'd0 || {1'b0, idx} >= NREG6) return '0;
    if (wb_valid && wb_wr && wb_dst == idx) return wb_val;
    return rf[idx[RW-1:0]];
  endfunction

  always_comb begin
    id_op     = id_instr[31:26];
    id_rs     = id_instr[25:21];
    id_rt     = id_instr[20:16];
    id_imm    = DW'($signed(id_instr[15:0]));
    id_rr     = id_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL};
    id_ri     = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
    id_dst    = id_rr ? id_instr[15:11] : id_rt;
    id_wr     = (id_rr || id_ri || id_op == OP_LW) && id_dst != 5'd0 && {1'b0, id_dst} < NREG6;
    id_use_rs = id_rr || id_ri || id_op inside {OP_LW, OP_SW, OP_BEQZ, OP_BNEQZ};
    id_use_rt = id_rr || id_op == OP_SW;
    id_hlt    = id_valid && id_op == OP_HLT;
    id_a      = rf_rd(id_rs);
    id_b      = rf_rd(id_rt);
  end

  // Youngest producer wins; loads in MEM are not yet forwardable (interlock covers them).
  always_comb begin
    fa = ex_a;
    fb = ex_b;
    if (mem_valid && mem_wr && mem_op != OP_LW && mem_dst == ex_rs) fa = mem_res;
    else if (wb_valid && wb_wr && wb_dst == ex_rs)                  fa = wb_val;
    if (mem_valid && mem_wr && mem_op != OP_LW && mem_dst == ex_rt) fb = mem_res;
    else if (wb_valid && wb_wr && wb_dst == ex_rt)                  fb = wb_val;
  end

  always_comb begin
    ex_res = '0;
    case (ex_op)
      OP_ADD:               ex_res = fa + fb;
      OP_SUB:               ex_res = fa - fb;
      OP_AND:               ex_res = fa & fb;
      OP_OR:                ex_res = fa | fb;
      OP_SLT:               ex_res[0] = $signed(fa) < $signed(fb);
      OP_MUL:               ex_res = fa * fb;
      OP_ADDI, OP_LW, OP_SW: ex_res = fa + ex_imm;
      OP_SUBI:              ex_res = fa - ex_imm;
      OP_SLTI:              ex_res[0] = $signed(fa) < $signed(ex_imm);
      default:              ex_res = '0;
    endcase
  end

  always_comb begin
    br_taken  = ex_valid && ((ex_op == OP_BEQZ && fa == '0) || (ex_op == OP_BNEQZ && fa != '0));
    br_target = ex_pc + PW'(1) + ex_imm[PW-1:0];
    ld_use    = ex_valid && ex_op == OP_LW && ex_wr && id_valid &&
                ((id_use_rs && id_rs == ex_dst) || (id_use_rt && id_rt == ex_dst));
    fetch_en  = bus.run && !halted_q && !hlt_pend && !id_hlt && !ld_use && !br_taken;
    mem_addr  = mem_res[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (bus.prog_we) imem[bus.prog_addr] <= bus.prog_data;
    if (mem_valid && mem_op == OP_SW) dmem[mem_addr] <= mem_sd;
    if (wb_valid && wb_wr) rf[wb_dst[RW-1:0]] <= wb_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      hlt_pend  <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
      ex_valid  <= 1'b0;
      ex_wr     <= 1'b0;
      ex_op     <= '0;
      ex_pc     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dst    <= '0;
      mem_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_op    <= '0;
      mem_res   <= '0;
      mem_sd    <= '0;
      mem_dst   <= '0;
      wb_valid  <= 1'b0;
      wb_wr     <= 1'b0;
      wb_op     <= '0;
      wb_val    <= '0;
      wb_dst    <= '0;
    end else begin
      if (br_taken) begin
        pc       <= br_target;
        id_valid <= 1'b0;
      end else if (!ld_use) begin
        if (fetch_en) begin
          id_valid <= 1'b1;
          id_instr <= imem[pc];
          id_pc    <= pc;
          pc       <= pc + PW'(1);
        end else begin
          id_valid <= 1'b0;
        end
      end

      // A HLT leaving ID unflushed freezes fetch until reset.
      if (id_hlt && !br_taken) hlt_pend <= 1'b1;

      ex_valid <= id_valid && !br_taken && !ld_use;
      ex_wr    <= id_wr;
      ex_op    <= id_op;
      ex_pc    <= id_pc;
      ex_a     <= id_a;
      ex_b     <= id_b;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_dst   <= id_dst;

      mem_valid <= ex_valid;
      mem_wr    <= ex_wr;
      mem_op    <= ex_op;
      mem_res   <= ex_res;
      mem_sd    <= fb;
      mem_dst   <= ex_dst;

      wb_valid <= mem_valid;
      wb_wr    <= mem_wr;
      wb_op    <= mem_op;
      wb_val   <= (mem_op == OP_LW) ? dmem[mem_addr] : mem_res;
      wb_dst   <= mem_dst;

      halted_q  <= halted_q || (wb_valid && wb_op == OP_HLT);
      retired_q <= retired_q + 32'(wb_valid);
    end
  end

  assign bus.dbg_data = dmem[bus.dbg_addr];
  assign bus.halted   = halted_q;
  assign bus.retired  = retired_q;
endmodule

// File: tb/tb_mips_pipe_param.sv
// Directed bench for mips_pipe_param: a DW=64 and a DW=16 core run the same
// programs side by side; results are read back through dbg_addr/dbg_data.
module tb_mips_pipe_param;
  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000101;
  localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101, OP_BEQZ = 6'b001110;
  localparam logic [31:0] HLT = {6'b111111, 26'd0};
  localparam logic [31:0] NOP = {6'b010000, 26'd0};

  typedef struct {
    string       nm;
    int          addr;
    logic [63:0] e64;
    logic [15:0] e16;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, run, prog_we;
  logic [9:0]  prog_addr, dbg_addr;
  logic [31:0] prog_data;
  logic [31:0] prog [$];
  int          checks = 0;
  int          errors = 0;

  mips_pipe_param_if #(.DW(64), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) if64 ();
  mips_pipe_param_if #(.DW(16), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) if16 ();

  assign if64.run = run;           assign if16.run = run;
  assign if64.prog_we = prog_we;   assign if16.prog_we = prog_we;
  assign if64.prog_addr = prog_addr; assign if16.prog_addr = prog_addr;
  assign if64.prog_data = prog_data; assign if16.prog_data = prog_data;
  assign if64.dbg_addr = dbg_addr; assign if16.dbg_addr = dbg_addr;

  mips_pipe_param #(.DW(64), .NREG(32), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024))
    dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
  mips_pipe_param #(.DW(16), .NREG(32), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024))
    dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic p(input logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic chk_run(input string nm, input int ret);
    chk({nm, "_ret64"}, 64'(if64.retired), 64'(ret));
    chk({nm, "_ret16"}, 64'(if16.retired), 64'(ret));
    chk({nm, "_halt64"}, 64'(if64.halted), 64'd1);
    chk({nm, "_halt16"}, 64'(if16.halted), 64'd1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 10'(i);
      prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
    prog.delete();
  endtask

  // cyc = edges after the first fetch edge until halted is seen.
  task automatic wait_halt(input string nm, output int cyc);
    cyc = 0;
    @(posedge clk);
    forever begin
      #1;
      if (if64.halted && if16.halted) break;
      if (cyc >= 400) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout got=no_halt exp=halt", nm);
        cyc = -1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic run_prog(input string nm, output int cyc);
    reset_pulse();
    load_prog();
    run = 1'b1;
    wait_halt(nm, cyc);
  endtask

  task automatic build_fact();
    p(ri(OP_ADDI, 10, 0, 200)); p(ri(OP_ADDI, 2, 0, 1)); p(ri(OP_LW, 3, 10, 0));
    p(rr(OP_MUL, 2, 2, 3));     p(ri(OP_SUBI, 3, 3, 1)); p(ri(OP_BNEQZ, 0, 3, -3));
    p(ri(OP_SW, 2, 10, -2));    p(HLT);
  endtask

  initial begin
    vec_t tbl [16];
    int   cyc;
    tbl[0]  = '{"dm0",    0,   64'd9,       16'd9};
    tbl[1]  = '{"dm200",  200, 64'd7,       16'd7};
    tbl[2]  = '{"ch_r2",  10,  64'd10,      16'd10};
    tbl[3]  = '{"ch_r3",  11,  64'd15,      16'd15};
    tbl[4]  = '{"ch_r4",  12,  64'd5,       16'd5};
    tbl[5]  = '{"lu_r6",  23,  64'd18,      16'd18};
    tbl[6]  = '{"nop_r6", 24,  64'd18,      16'd18};
    tbl[7]  = '{"br_r7",  20,  64'd0,       16'd0};
    tbl[8]  = '{"br_r8",  21,  64'd0,       16'd0};
    tbl[9]  = '{"br_r9",  22,  64'd3,       16'd3};
    tbl[10] = '{"nt_r7",  25,  64'd4,       16'd4};
    tbl[11] = '{"hf_r11", 26,  64'd6,       16'd6};
    tbl[12] = '{"fact",   198, 64'd5040,    16'd5040};
    tbl[13] = '{"w_r1",   30,  64'h8000,    16'h8000};
    tbl[14] = '{"w_slti", 31,  64'd0,       16'd1};
    tbl[15] = '{"w_mul",  32,  64'h10000,   16'h0000};

    rst_n = 1'b0; run = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ret64", 64'(if64.retired), 64'd0);
    chk("rst_ret16", 64'(if16.retired), 64'd0);
    chk("rst_halt64", 64'(if64.halted), 64'd0);
    chk("rst_halt16", 64'(if16.halted), 64'd0);
    rst_n = 1'b1;

    // Registers and memories power up unknown: clear R1..R31 and seed data memory.
    for (int k = 1; k < 32; k++) p(rr(OP_ADD, k, 0, 0));
    p(ri(OP_ADDI, 1, 0, 7)); p(ri(OP_SW, 1, 0, 200));
    p(ri(OP_ADDI, 1, 0, 9)); p(ri(OP_SW, 1, 0, 0));
    p(ri(OP_SW, 0, 0, 198)); p(HLT);
    run_prog("setup", cyc);
    chk_run("setup", 37);

    p(ri(OP_ADDI, 1, 0, 5)); p(rr(OP_ADD, 2, 1, 1)); p(rr(OP_ADD, 3, 2, 1));
    p(rr(OP_SUB, 4, 3, 2));  p(HLT);
    run_prog("chain", cyc);
    chk("chain_cyc", 64'(cyc), 64'd8);
    chk_run("chain", 5);
    p(ri(OP_SW, 2, 0, 10)); p(ri(OP_SW, 3, 0, 11)); p(ri(OP_SW, 4, 0, 12)); p(HLT);
    run_prog("dump_chain", cyc);

    p(ri(OP_LW, 5, 0, 0)); p(rr(OP_ADD, 6, 5, 5)); p(HLT);
    run_prog("lduse", cyc);
    chk("lduse_cyc", 64'(cyc), 64'd7);
    chk_run("lduse", 3);
    p(ri(OP_SW, 6, 0, 23)); p(HLT);
    run_prog("dump_lu", cyc);

    p(ri(OP_LW, 5, 0, 0)); p(NOP); p(rr(OP_ADD, 6, 5, 5)); p(HLT);
    run_prog("nopgap", cyc);
    chk("nopgap_cyc", 64'(cyc), 64'd7);
    chk_run("nopgap", 4);
    p(ri(OP_SW, 6, 0, 24)); p(HLT);
    run_prog("dump_nop", cyc);

    p(ri(OP_BEQZ, 0, 0, 2)); p(ri(OP_ADDI, 7, 0, 1)); p(ri(OP_ADDI, 8, 0, 1));
    p(ri(OP_ADDI, 9, 0, 3)); p(HLT);
    run_prog("branch", cyc);
    chk("branch_cyc", 64'(cyc), 64'd8);
    chk_run("branch", 3);
    p(ri(OP_SW, 7, 0, 20)); p(ri(OP_SW, 8, 0, 21)); p(ri(OP_SW, 9, 0, 22)); p(HLT);
    run_prog("dump_br", cyc);

    p(ri(OP_BNEQZ, 0, 0, 2)); p(ri(OP_ADDI, 7, 0, 4)); p(HLT);
    run_prog("nottaken", cyc);
    chk("nottaken_cyc", 64'(cyc), 64'd6);
    chk_run("nottaken", 3);

    // HLT sitting in ID is squashed by the older taken branch; fetch resumes at target.
    p(ri(OP_BEQZ, 0, 0, 1)); p(HLT); p(ri(OP_ADDI, 11, 0, 6)); p(HLT);
    run_prog("hltflush", cyc);
    chk("hltflush_cyc", 64'(cyc), 64'd8);
    chk_run("hltflush", 3);
    p(ri(OP_SW, 7, 0, 25)); p(ri(OP_SW, 11, 0, 26)); p(HLT);
    run_prog("dump_hf", cyc);

    build_fact();
    run_prog("fact", cyc);
    chk("fact_cyc", 64'(cyc), 64'd42);
    chk_run("fact", 26);
    dbg_addr = 10'd198;
    #1;
    chk("fact_dm64", if64.dbg_data, 64'd5040);
    chk("fact_dm16", 64'(if16.dbg_data), 64'd5040);
    repeat (5) @(negedge clk);
    chk_run("fact_sticky", 26);

    p(ri(OP_SW, 0, 0, 198)); p(HLT);
    run_prog("clr198", cyc);

    reset_pulse();
    build_fact();
    load_prog();
    run = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    dbg_addr = 10'd198;
    #1;
    chk("mid_ret64", 64'(if64.retired), 64'd0);
    chk("mid_ret16", 64'(if16.retired), 64'd0);
    chk("mid_halt64", 64'(if64.halted), 64'd0);
    chk("mid_dm198", if64.dbg_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    wait_halt("rerun", cyc);
    chk("rerun_cyc", 64'(cyc), 64'd42);
    chk_run("rerun", 26);

    p(ri(OP_ADDI, 1, 0, 32'h7FFF)); p(ri(OP_ADDI, 1, 1, 1)); p(ri(OP_SLTI, 2, 1, 0));
    p(ri(OP_ADDI, 3, 0, 256));      p(rr(OP_MUL, 4, 3, 3));
    p(ri(OP_SW, 1, 0, 30)); p(ri(OP_SW, 2, 0, 31)); p(ri(OP_SW, 4, 0, 32)); p(HLT);
    run_prog("width", cyc);
    chk_run("width", 9);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dbg_addr = 10'(tbl[i].addr);
      #1;
      chk({tbl[i].nm, "_64"}, if64.dbg_data, tbl[i].e64);
      chk({tbl[i].nm, "_16"}, 64'(if16.dbg_data), 64'(tbl[i].e16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
